// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
//  arb_state_t : access sequencer states (idle, one-cycle issue, read wait)
//  arb_grant_t : which requester currently owns the memory
//  RD_CNT_W    : width of the read-latency wait counter (latency 1..7)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_grant_t;

  localparam int RD_CNT_W = 3;

endpackage

// File: rtl/unified_memory_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter.
//  clk, rst_n : clock, synchronous active-low reset
//  req[1:0]   : request vector, bit0 = IF, bit1 = DM
//  en         : arbitration allowed this cycle (grants are zero otherwise)
//  gnt[1:0]   : one-hot (or zero) combinational grant
// On a conflict the requester that did not win last time is granted. The
// last winner resets to DM so the first conflict after reset goes to IF.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  arb_grant_t last_grant_reg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant_reg == GNT_DM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= GNT_DM;
    end else if (en && (req != 2'b00)) begin
      last_grant_reg <= gnt[1] ? GNT_DM : GNT_IF;
    end
  end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Unified instruction/data memory arbiter.
// Shares one single-port memory between the fetch unit (IF, read only) and
// the load/store unit (DM, read/write). Round-robin grant, one-cycle issue,
// RD_LATENCY-cycle read wait, one-cycle response pulse to the winner.
//  if_req_*   : fetch request (valid/addr) and ready
//  if_rsp_*   : fetch response pulse and data
//  dm_req_*   : data request (valid/addr/we/wdata) and ready
//  dm_rsp_*   : data response pulse (read data or write ack) and data
//  mem_*      : memory strobe, address, write data/enable, read data
//  busy       : sequencer not idle
// Optional: define MEM_ARB_STATS_EN to add grant/conflict counters
//  (stat_if_grants, stat_dm_grants, stat_conflicts).
module unified_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  dm_req_valid,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic                  dm_req_we,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rsp_data,
  output logic                  mem_chip_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]           stat_if_grants,
  output logic [31:0]           stat_dm_grants,
  output logic [31:0]           stat_conflicts,
`endif
  output logic                  busy
);

  localparam logic [RD_CNT_W-1:0] CNT_INIT = RD_CNT_W'(RD_LATENCY - 1);

  arb_state_t            state_reg;
  arb_grant_t            grant_reg;
  logic                  we_reg;
  logic [RD_CNT_W-1:0]   cnt_reg;
  logic                  mem_chip_sel_reg;
  logic                  mem_wr_en_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wr_data_reg;
  logic                  if_rsp_valid_reg;
  logic [DATA_WIDTH-1:0] if_rsp_data_reg;
  logic                  dm_rsp_valid_reg;
  logic [DATA_WIDTH-1:0] dm_rsp_data_reg;
  logic [1:0]            gnt;
  logic                  arb_en;

  assign arb_en = (state_reg == ST_IDLE);

  rr_arbiter_2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({dm_req_valid, if_req_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  // The memory-side registers double as the request latches: they are
  // loaded at the grant edge so they are already valid during ISSUE, and
  // simply hold their value afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      grant_reg        <= GNT_IF;
      we_reg           <= 1'b0;
      cnt_reg          <= '0;
      mem_chip_sel_reg <= 1'b0;
      mem_wr_en_reg    <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wr_data_reg  <= '0;
      if_rsp_valid_reg <= 1'b0;
      if_rsp_data_reg  <= '0;
      dm_rsp_valid_reg <= 1'b0;
      dm_rsp_data_reg  <= '0;
    end else begin
      if_rsp_valid_reg <= 1'b0;
      dm_rsp_valid_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (gnt[0]) begin
            grant_reg        <= GNT_IF;
            we_reg           <= 1'b0;
            mem_addr_reg     <= if_req_addr;
            mem_wr_en_reg    <= 1'b0;
            mem_chip_sel_reg <= 1'b1;
            state_reg        <= ST_ISSUE;
          end else if (gnt[1]) begin
            grant_reg        <= GNT_DM;
            we_reg           <= dm_req_we;
            mem_addr_reg     <= dm_req_addr;
            mem_wr_data_reg  <= dm_req_wdata;
            mem_wr_en_reg    <= dm_req_we;
            mem_chip_sel_reg <= 1'b1;
            state_reg        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_chip_sel_reg <= 1'b0;
          mem_wr_en_reg    <= 1'b0;
          if (we_reg) begin
            dm_rsp_valid_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end else begin
            cnt_reg   <= CNT_INIT;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            if (grant_reg == GNT_IF) begin
              if_rsp_data_reg  <= mem_rd_data;
              if_rsp_valid_reg <= 1'b1;
            end else begin
              dm_rsp_data_reg  <= mem_rd_data;
              dm_rsp_valid_reg <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_reg;
  logic [31:0] stat_dm_reg;
  logic [31:0] stat_conf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_if_reg   <= '0;
      stat_dm_reg   <= '0;
      stat_conf_reg <= '0;
    end else begin
      if (gnt[0]) stat_if_reg <= stat_if_reg + 32'd1;
      if (gnt[1]) stat_dm_reg <= stat_dm_reg + 32'd1;
      if (arb_en && if_req_valid && dm_req_valid) stat_conf_reg <= stat_conf_reg + 32'd1;
    end
  end

  assign stat_if_grants = stat_if_reg;
  assign stat_dm_grants = stat_dm_reg;
  assign stat_conflicts = stat_conf_reg;
`endif

  assign if_req_ready = gnt[0];
  assign dm_req_ready = gnt[1];
  assign if_rsp_valid = if_rsp_valid_reg;
  assign if_rsp_data  = if_rsp_data_reg;
  assign dm_rsp_valid = dm_rsp_valid_reg;
  assign dm_rsp_data  = dm_rsp_data_reg;
  assign mem_chip_sel = mem_chip_sel_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wr_data  = mem_wr_data_reg;
  assign mem_wr_en    = mem_wr_en_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Testbench for unified_memory_arbiter: two instances (read latency 1 and 3),
// each with a small behavioural memory, checked cycle by cycle against a
// transaction-level model (free-at time, response due times, reference memory).
module tb_unified_memory_arbiter;

  logic        clk;
  logic        mem_init;
  logic        rst_n        [2];
  logic        if_req_valid [2];
  logic [31:0] if_req_addr  [2];
  logic        if_req_ready [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rsp_data  [2];
  logic        dm_req_valid [2];
  logic [31:0] dm_req_addr  [2];
  logic        dm_req_we    [2];
  logic [31:0] dm_req_wdata [2];
  logic        dm_req_ready [2];
  logic        dm_rsp_valid [2];
  logic [31:0] dm_rsp_data  [2];
  logic        mem_chip_sel [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wr_data  [2];
  logic        mem_wr_en    [2];
  logic [31:0] mem_rd_data  [2];
  logic        busy         [2];
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_grants [2];
  logic [31:0] stat_dm_grants [2];
  logic [31:0] stat_conflicts [2];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    logic [31:0] mem  [32];
    logic [31:0] pipe [L];

    unified_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(L)) dut (
      .clk          (clk),
      .rst_n        (rst_n[gi]),
      .if_req_valid (if_req_valid[gi]),
      .if_req_addr  (if_req_addr[gi]),
      .if_req_ready (if_req_ready[gi]),
      .if_rsp_valid (if_rsp_valid[gi]),
      .if_rsp_data  (if_rsp_data[gi]),
      .dm_req_valid (dm_req_valid[gi]),
      .dm_req_addr  (dm_req_addr[gi]),
      .dm_req_we    (dm_req_we[gi]),
      .dm_req_wdata (dm_req_wdata[gi]),
      .dm_req_ready (dm_req_ready[gi]),
      .dm_rsp_valid (dm_rsp_valid[gi]),
      .dm_rsp_data  (dm_rsp_data[gi]),
      .mem_chip_sel (mem_chip_sel[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_wr_data  (mem_wr_data[gi]),
      .mem_wr_en    (mem_wr_en[gi]),
      .mem_rd_data  (mem_rd_data[gi]),
`ifdef MEM_ARB_STATS_EN
      .stat_if_grants (stat_if_grants[gi]),
      .stat_dm_grants (stat_dm_grants[gi]),
      .stat_conflicts (stat_conflicts[gi]),
`endif
      .busy         (busy[gi])
    );

    // Memory: word index {region bit, addr[5:2]}, data valid L cycles after the issue edge.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'h2002_0001 + 32'(i);
      end else if (mem_chip_sel[gi] && mem_wr_en[gi]) begin
        mem[{mem_addr[gi][31], mem_addr[gi][5:2]}] <= mem_wr_data[gi];
      end
      pipe[0] <= (mem_chip_sel[gi] && !mem_wr_en[gi]) ? mem[{mem_addr[gi][31], mem_addr[gi][5:2]}] : 32'h0BAD_0BAD;
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rd_data[gi] = pipe[L-1];
  end

  int total, bad;
  int cyc;

  // Transaction-level model state, per instance
  int          free_at   [2];
  int          issue_at  [2];
  int          if_rsp_at [2];
  int          dm_rsp_at [2];
  bit          last_dm   [2];
  logic [31:0] issue_addr[2];
  logic [31:0] issue_wd  [2];
  bit          issue_we  [2];
  bit          dm_pend_wr[2];
  logic [31:0] if_pend   [2];
  logic [31:0] dm_pend   [2];
  logic [31:0] if_data_m [2];
  logic [31:0] dm_data_m [2];
  logic [31:0] mem_addr_m[2];
  logic [31:0] ref_mem   [2][32];
  int          n_if_m    [2];
  int          n_dm_m    [2];
  int          n_conf_m  [2];
  bit          acc_if, acc_dm;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'({a[31], a[5:2]});
  endfunction

  task automatic model_reset(input int k);
    free_at[k] = cyc; issue_at[k] = -1; if_rsp_at[k] = -1; dm_rsp_at[k] = -1;
    last_dm[k] = 1'b1; if_data_m[k] = '0; dm_data_m[k] = '0; mem_addr_m[k] = '0;
    n_if_m[k] = 0; n_dm_m[k] = 0; n_conf_m[k] = 0;
  endtask

  task automatic clear_in(input int k);
    if_req_valid[k] = 1'b0; if_req_addr[k] = '0;
    dm_req_valid[k] = 1'b0; dm_req_addr[k] = '0; dm_req_we[k] = 1'b0; dm_req_wdata[k] = '0;
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    clear_in(k);
    @(posedge clk); cyc++;
    @(negedge clk);
    rst_n[k] = 1'b1;
    model_reset(k);
  endtask

  // One clock cycle for instance k: inputs already driven at the negedge.
  task automatic step(input int k);
    bit idle, g_if, g_dm, exp_cs;
    #1;
    idle   = (cyc >= free_at[k]);
    g_if   = idle && if_req_valid[k] && (!dm_req_valid[k] || last_dm[k]);
    g_dm   = idle && dm_req_valid[k] && (!if_req_valid[k] || !last_dm[k]);
    exp_cs = (cyc == issue_at[k]);
    if (exp_cs) mem_addr_m[k] = issue_addr[k];
    if (cyc == if_rsp_at[k]) if_data_m[k] = if_pend[k];
    if (cyc == dm_rsp_at[k] && !dm_pend_wr[k]) dm_data_m[k] = dm_pend[k];
    chk("if_req_ready", if_req_ready[k], g_if);
    chk("dm_req_ready", dm_req_ready[k], g_dm);
    chk("both_ready", if_req_ready[k] && dm_req_ready[k], 1'b0);
    chk("busy", busy[k], !idle);
    chk("mem_chip_sel", mem_chip_sel[k], exp_cs);
    chk("mem_wr_en", mem_wr_en[k], exp_cs && issue_we[k]);
    chk("mem_addr", mem_addr[k], mem_addr_m[k]);
    if (exp_cs && issue_we[k]) chk("mem_wr_data", mem_wr_data[k], issue_wd[k]);
    chk("if_rsp_valid", if_rsp_valid[k], cyc == if_rsp_at[k]);
    chk("if_rsp_data", if_rsp_data[k], if_data_m[k]);
    chk("dm_rsp_valid", dm_rsp_valid[k], cyc == dm_rsp_at[k]);
    chk("dm_rsp_data", dm_rsp_data[k], dm_data_m[k]);
`ifdef MEM_ARB_STATS_EN
    chk("stat_if", stat_if_grants[k], 32'(n_if_m[k]));
    chk("stat_dm", stat_dm_grants[k], 32'(n_dm_m[k]));
    chk("stat_conf", stat_conflicts[k], 32'(n_conf_m[k]));
`endif
    if (idle && if_req_valid[k] && dm_req_valid[k]) n_conf_m[k]++;
    acc_if = g_if;
    acc_dm = g_dm;
    if (g_if) begin
      n_if_m[k]++;
      last_dm[k] = 1'b0; issue_at[k] = cyc + 1; issue_addr[k] = if_req_addr[k]; issue_we[k] = 1'b0;
      free_at[k] = cyc + lat(k) + 2; if_rsp_at[k] = free_at[k];
      if_pend[k] = ref_mem[k][widx(if_req_addr[k])];
    end
    if (g_dm) begin
      n_dm_m[k]++;
      last_dm[k] = 1'b1; issue_at[k] = cyc + 1; issue_addr[k] = dm_req_addr[k];
      issue_we[k] = dm_req_we[k]; issue_wd[k] = dm_req_wdata[k]; dm_pend_wr[k] = dm_req_we[k];
      if (dm_req_we[k]) begin
        ref_mem[k][widx(dm_req_addr[k])] = dm_req_wdata[k];
        free_at[k] = cyc + 2;
      end else begin
        dm_pend[k] = ref_mem[k][widx(dm_req_addr[k])];
        free_at[k] = cyc + lat(k) + 2;
      end
      dm_rsp_at[k] = free_at[k];
    end
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic idle_steps(input int k, input int n);
    clear_in(k);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic random_run(input int k, input int n);
    logic [31:0] a;
    clear_in(k);
    for (int i = 0; i < n; i++) begin
      if (!if_req_valid[k] || acc_if) begin
        a = $urandom;
        if_req_valid[k] = ($urandom_range(0, 2) == 0);
        if_req_addr[k]  = a & 32'h8000_003F;
      end else if ($urandom_range(0, 15) == 0) begin
        if_req_valid[k] = 1'b0;
      end
      if (!dm_req_valid[k] || acc_dm) begin
        a = $urandom;
        dm_req_valid[k] = ($urandom_range(0, 2) == 0);
        dm_req_addr[k]  = a & 32'h8000_003F;
        dm_req_we[k]    = ($urandom_range(0, 1) == 1);
        dm_req_wdata[k] = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req_valid[k] = 1'b0;
      end
      step(k);
    end
    idle_steps(k, 6);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    acc_if = 1'b0; acc_dm = 1'b0;
    mem_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      clear_in(k);
      for (int i = 0; i < 32; i++) ref_mem[k][i] = 32'h2002_0001 + 32'(i);
      issue_we[k] = 1'b0; dm_pend_wr[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    model_reset(0); model_reset(1);

    // Reset state
    #1;
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_chip_sel", mem_chip_sel[0], 1'b0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    chk("rst_if_rsp_data", if_rsp_data[0], 32'h0);
    @(negedge clk); cyc++;

    // 1: IF read 0x10 alone, latency 1
    if_req_valid[0] = 1'b1; if_req_addr[0] = 32'h0000_0010;
    step(0);
    clear_in(0);
    #1;
    chk("t1_chip_sel_cyc1", mem_chip_sel[0], 1'b1);
    chk("t1_addr_cyc1", mem_addr[0], 32'h0000_0010);
    step(0); step(0);
    #1;
    chk("t1_if_rsp_valid_cyc3", if_rsp_valid[0], 1'b1);
    chk("t1_if_rsp_data", if_rsp_data[0], 32'h2002_0005);
    chk("t1_dm_silent", dm_rsp_valid[0], 1'b0);
    idle_steps(0, 3);

    // 2: DM write 0x8000_0004 = 0xDEAD_BEEF
    dm_req_valid[0] = 1'b1; dm_req_addr[0] = 32'h8000_0004; dm_req_we[0] = 1'b1; dm_req_wdata[0] = 32'hDEAD_BEEF;
    step(0);
    clear_in(0);
    #1;
    chk("t2_chip_sel", mem_chip_sel[0], 1'b1);
    chk("t2_wr_en", mem_wr_en[0], 1'b1);
    chk("t2_addr", mem_addr[0], 32'h8000_0004);
    chk("t2_wdata", mem_wr_data[0], 32'hDEAD_BEEF);
    step(0);
    #1;
    chk("t2_dm_rsp_valid_cyc2", dm_rsp_valid[0], 1'b1);
    idle_steps(0, 3);
    // read back the written word
    dm_req_valid[0] = 1'b1; dm_req_addr[0] = 32'h8000_0004; dm_req_we[0] = 1'b0;
    step(0);
    idle_steps(0, 4);
    chk("t2_readback", dm_rsp_data[0], 32'hDEAD_BEEF);

    // 3: four conflicts after reset -> IF, DM, IF, DM
    do_reset(0);
    if_req_valid[0] = 1'b1; if_req_addr[0] = 32'h0000_0008;
    dm_req_valid[0] = 1'b1; dm_req_addr[0] = 32'h8000_000C; dm_req_we[0] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (t % 3 == 0) begin
        #1;
        chk("t3_if_grant_order", if_req_ready[0], ((t / 3) % 2) == 0);
        chk("t3_dm_grant_order", dm_req_ready[0], ((t / 3) % 2) == 1);
      end
      step(0);
    end
    clear_in(0);
`ifdef MEM_ARB_STATS_EN
    #1;
    chk("t6_stat_if", stat_if_grants[0], 32'd2);
    chk("t6_stat_dm", stat_dm_grants[0], 32'd2);
    chk("t6_stat_conf", stat_conflicts[0], 32'd4);
`endif
    idle_steps(0, 4);

    // 4: latency 3, DM read 0x8000_0000, IF waits and is accepted on rsp cycle
    do_reset(1);
    dm_req_valid[1] = 1'b1; dm_req_addr[1] = 32'h8000_0000; dm_req_we[1] = 1'b0;
    step(1);
    clear_in(1);
    if_req_valid[1] = 1'b1; if_req_addr[1] = 32'h0000_0020;
    for (int t = 1; t < 5; t++) step(1);
    #1;
    chk("t4_dm_rsp_valid_cyc5", dm_rsp_valid[1], 1'b1);
    chk("t4_dm_rsp_data", dm_rsp_data[1], 32'h2002_0011);
    chk("t4_if_ready_cyc5", if_req_ready[1], 1'b1);
    step(1);
    clear_in(1);
    step(1); step(1);

    // 5: reset while in WAIT aborts the read
    #1;
    chk("t5_in_wait", busy[1], 1'b1);
    do_reset(1);
    #1;
    chk("t5_busy_after_rst", busy[1], 1'b0);
    chk("t5_chip_sel_after_rst", mem_chip_sel[1], 1'b0);
    chk("t5_if_rsp_data_after_rst", if_rsp_data[1], 32'h0);
    chk("t5_dm_rsp_data_after_rst", dm_rsp_data[1], 32'h0);
    idle_steps(1, 5);
    if_req_valid[1] = 1'b1; if_req_addr[1] = 32'h0000_0004;
    dm_req_valid[1] = 1'b1; dm_req_addr[1] = 32'h8000_0008; dm_req_we[1] = 1'b1; dm_req_wdata[1] = 32'h1234_5678;
    #1;
    chk("t5_conflict_grants_if", if_req_ready[1], 1'b1);
    step(1);
    if_req_valid[1] = 1'b0;
    for (int t = 0; t < 6; t++) step(1);
    idle_steps(1, 4);

    // Randomized traffic on both latencies
    random_run(0, 400);
    random_run(1, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
